// File: rtl/adder_pkg.sv
// Shared sizing helpers for the chunked arithmetic datapaths.
// Holds constant functions only, so any datapath can import it without pulling in types.
package adder_pkg;

  function automatic int unsigned nstage(input int unsigned width,
                                         input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // The last slice takes whatever bits remain after the full-width slices.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned chunk,
                                              input int unsigned s);
    return (s == nstage(width, chunk) - 1) ? width - s * chunk : chunk;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: adds its operand slice plus the incoming carry and merges the
// slice result into the partial sum. Holds while i_en is low; clears asynchronously.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned CHUNK = 16,
  parameter  int unsigned STAGE = 0,
  localparam int unsigned SW    = slice_width(WIDTH, CHUNK, STAGE),
  localparam int unsigned LO    = STAGE * CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [SW-1:0]    i_a,
  input  logic [SW-1:0]    i_b,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_sum,
  output logic             o_valid,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_sum
);

  logic [SW:0]      w_slice;
  logic [WIDTH-1:0] w_sum;
  logic             r_valid;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;

  assign w_slice = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};

  always_comb begin
    w_sum          = i_sum;
    w_sum[LO +: SW] = w_slice[SW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_carry <= w_slice[SW];
      r_sum   <= w_sum;
    end
  end

  assign o_valid = r_valid;
  assign o_carry = r_carry;
  assign o_sum   = r_sum;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined unsigned adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, whole pipe advancing together under a valid/ready handshake.
module pipelined_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int unsigned NSTAGE = nstage(WIDTH, CHUNK);

  logic              w_adv;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;
  logic [NSTAGE-1:0] w_valid;
  logic [NSTAGE-1:0] w_carry;
  logic [WIDTH-1:0]  w_sum [NSTAGE];

  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;
  assign w_b_eff   = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub | in_cin;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_st
    localparam int unsigned REMW = WIDTH - s * CHUNK;
    localparam int unsigned SW   = slice_width(WIDTH, CHUNK, s);

    // w_opa/w_opb hold the operand bits not yet added, right-aligned to this stage's slice.
    logic [REMW-1:0]  w_opa;
    logic [REMW-1:0]  w_opb;
    logic             w_vin;
    logic             w_cin;
    logic [WIDTH-1:0] w_sin;

    if (s == 0) begin : g_in
      assign w_opa = in_a;
      assign w_opb = w_b_eff;
      assign w_vin = in_valid;
      assign w_cin = w_cin_eff;
      assign w_sin = '0;
    end else begin : g_fwd
      logic [REMW-1:0] r_opa;
      logic [REMW-1:0] r_opb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_opa <= '0;
          r_opb <= '0;
        end else if (w_adv) begin
          r_opa <= g_st[s-1].w_opa[REMW+CHUNK-1:CHUNK];
          r_opb <= g_st[s-1].w_opb[REMW+CHUNK-1:CHUNK];
        end
      end

      assign w_opa = r_opa;
      assign w_opb = r_opb;
      assign w_vin = w_valid[s-1];
      assign w_cin = w_carry[s-1];
      assign w_sin = w_sum[s-1];
    end

    adder_chunk_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .STAGE(s)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_adv),
      .i_valid(w_vin),
      .i_a    (w_opa[SW-1:0]),
      .i_b    (w_opb[SW-1:0]),
      .i_cin  (w_cin),
      .i_sum  (w_sin),
      .o_valid(w_valid[s]),
      .o_carry(w_carry[s]),
      .o_sum  (w_sum[s])
    );
  end

  assign out_valid = w_valid[NSTAGE-1];
  assign out_sum   = {w_carry[NSTAGE-1], w_sum[NSTAGE-1]};

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed bench for pipelined_chunk_adder: 64/16 (four stages), 63/16 (narrow last
// slice) and 8/12 (single stage) instances sharing one clock and reset.
module tb_pipelined_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv64, ir64, ov64, ordy64, sub64, cin64;
  logic [63:0] a64, b64;
  logic [64:0] os64;

  logic        iv63, ir63, ov63, ordy63, sub63, cin63;
  logic [62:0] a63, b63;
  logic [63:0] os63;

  logic        iv8, ir8, ov8, ordy8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic [8:0]  os8;

  int n_pass   = 0;
  int n_checks = 0;
  int n_in, n_out;
  logic [64:0] snap;
  logic [63:0] bp_a [8];
  logic [63:0] bp_b [8];
  logic [7:0]  bp_sub, bp_cin;
  logic [63:0] q63 [$];

  pipelined_chunk_adder #(.WIDTH(64), .CHUNK(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .in_a(a64), .in_b(b64),
    .in_sub(sub64), .in_cin(cin64), .out_valid(ov64), .out_ready(ordy64), .out_sum(os64));

  pipelined_chunk_adder #(.WIDTH(63), .CHUNK(16)) u_dut63 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv63), .in_ready(ir63), .in_a(a63), .in_b(b63),
    .in_sub(sub63), .in_cin(cin63), .out_valid(ov63), .out_ready(ordy63), .out_sum(os63));

  pipelined_chunk_adder #(.WIDTH(8), .CHUNK(12)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_sub(sub8), .in_cin(cin8), .out_valid(ov8), .out_ready(ordy8), .out_sum(os8));

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] m64(input logic [63:0] a, input logic [63:0] b,
                                      input logic sub, input logic cin);
    return {1'b0, a} + {1'b0, (sub ? ~b : b)} + {64'd0, (sub | cin)};
  endfunction

  function automatic logic [63:0] m63(input logic [62:0] a, input logic [62:0] b,
                                      input logic sub, input logic cin);
    return {1'b0, a} + {1'b0, (sub ? ~b : b)} + {63'd0, (sub | cin)};
  endfunction

  // Sends one beat into the 64-bit pipe and checks exact 4-cycle latency and the result.
  task automatic send64(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic cin, input logic [64:0] exp);
    a64 = a; b64 = b; sub64 = sub; cin64 = cin; iv64 = 1'b1;
    tick();
    iv64 = 1'b0;
    tick(); chk({tag, "_lat1"}, {64'd0, ov64}, 65'd0);
    tick(); chk({tag, "_lat2"}, {64'd0, ov64}, 65'd0);
    tick(); chk({tag, "_valid"}, {64'd0, ov64}, 65'd1);
    chk(tag, os64, exp);
  endtask

  initial begin
    rst_n = 1'b1;
    {iv64, sub64, cin64, iv63, sub63, cin63, iv8, sub8, cin8} = '0;
    {ordy64, ordy63, ordy8} = '1;
    a64 = '0; b64 = '0; a63 = '0; b63 = '0; a8 = '0; b8 = '0;
    bp_a = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'h8000_0000_0000_0000,
             64'h0, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
             64'h5555_5555_5555_5555};
    bp_b = '{64'h1111_1111_1111_1111, 64'h0001_FFFF_0001_FFFF, 64'h8000_0000_0000_0000,
             64'h1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
             64'hAAAA_AAAA_AAAA_AAAA};
    bp_sub = 8'b0110_1010;
    bp_cin = 8'b1001_0101;

    // Reset asserted mid-cycle, before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ov64", {64'd0, ov64}, 65'd0);
    chk("rst_os64", os64, 65'd0);
    chk("rst_ov63", {64'd0, ov63}, 65'd0);
    chk("rst_ov8", {64'd0, ov8}, 65'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_ir64", {64'd0, ir64}, 65'd1);
    chk("rst_ir8", {64'd0, ir8}, 65'd1);

    send64("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 65'h1_0000_0000_0000_0000);
    send64("sub_lt", 64'd5, 64'd7, 1'b1, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFE);
    send64("sub_ge", 64'd7, 64'd5, 1'b1, 1'b0, 65'h1_0000_0000_0000_0002);
    send64("sub_eq", 64'h1234, 64'h1234, 1'b1, 1'b0, 65'h1_0000_0000_0000_0000);
    send64("mid_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
           65'h0_0001_0000_0001_0000);
    tick();

    // Back-to-back stream with out_ready low for three cycles mid-stream.
    n_in = 0; n_out = 0;
    for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
      ordy64 = !(cyc >= 5 && cyc < 8);
      iv64   = (n_in < 8);
      if (n_in < 8) begin
        a64 = bp_a[n_in]; b64 = bp_b[n_in]; sub64 = bp_sub[n_in]; cin64 = bp_cin[n_in];
      end
      #1;
      if (cyc == 5) snap = os64;
      if (!ordy64 && ov64) begin
        chk("bp_ready", {64'd0, ir64}, 65'd0);
        if (cyc > 5) chk("bp_hold", os64, snap);
      end
      if (ov64 && ordy64) begin
        chk("bp_res", os64, m64(bp_a[n_out], bp_b[n_out], bp_sub[n_out], bp_cin[n_out]));
        n_out++;
      end
      if (iv64 && ir64) n_in++;
      @(posedge clk);
      #1;
    end
    iv64 = 1'b0; ordy64 = 1'b1;
    chk("bp_count", 65'(n_out), 65'd8);
    tick();
    chk("bp_drain", {64'd0, ov64}, 65'd0);

    // Async reset with three beats in flight.
    iv64 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a64 = 64'(i + 1); b64 = 64'd10; sub64 = 1'b0; cin64 = 1'b0;
      tick();
    end
    iv64 = 1'b0;
    tick();
    chk("rst_pre", {64'd0, ov64}, 65'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_v", {64'd0, ov64}, 65'd0);
    chk("rst_async_sum", os64, 65'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_flush", {64'd0, ov64}, 65'd0);
    end

    // Narrow last slice: the carry lands in bit 63.
    a63 = 63'h7FFF_FFFF_FFFF_FFFF; b63 = 63'd1; iv63 = 1'b1;
    tick();
    iv63 = 1'b0;
    tick(); chk("w63_lat1", {64'd0, ov63}, 65'd0);
    tick(); chk("w63_lat2", {64'd0, ov63}, 65'd0);
    tick(); chk("w63_valid", {64'd0, ov63}, 65'd1);
    chk("w63_carry", {1'b0, os63}, 65'h0_8000_0000_0000_0000);
    tick();

    // Randomised traffic on the 63-bit pipe against the bench model.
    n_in = 0; n_out = 0;
    for (int cyc = 0; cyc < 60000 && n_out < 10000; cyc++) begin
      iv63   = (n_in < 10000) && ($urandom_range(3) != 0);
      ordy63 = ($urandom_range(3) != 0);
      a63    = 63'({$urandom(), $urandom()});
      b63    = 63'({$urandom(), $urandom()});
      sub63  = 1'($urandom_range(1));
      cin63  = 1'($urandom_range(1));
      #1;
      if (ov63 && ordy63) begin
        chk("rnd63", {1'b0, os63}, (q63.size() > 0) ? {1'b0, q63.pop_front()} : '1);
        n_out++;
      end
      if (iv63 && ir63) begin
        q63.push_back(m63(a63, b63, sub63, cin63));
        n_in++;
      end
      @(posedge clk);
      #1;
    end
    iv63 = 1'b0; ordy63 = 1'b1;
    chk("rnd63_count", 65'(n_out), 65'd10000);

    // Single-stage instance: latency 1, stall hold, drain+accept on the same edge.
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; iv8 = 1'b1;
    tick();
    chk("n1_valid", {64'd0, ov8}, 65'd1);
    chk("n1_add", {56'd0, os8}, 65'h100);
    a8 = 8'h03; b8 = 8'h03; sub8 = 1'b1;
    tick();
    chk("n1_sub_eq", {56'd0, os8}, 65'h100);
    a8 = 8'h02; b8 = 8'h03; ordy8 = 1'b0;
    #1;
    chk("n1_stall_ready", {64'd0, ir8}, 65'd0);
    tick();
    chk("n1_hold", {56'd0, os8}, 65'h100);
    ordy8 = 1'b1;
    tick();
    chk("n1_sub_lt", {56'd0, os8}, 65'h0FF);
    iv8 = 1'b0;
    tick();
    chk("n1_drain", {64'd0, ov8}, 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
